tl_sensor_cond: RTL



---
 rtl/tl_sensor_pkg.sv | 14 +
 rtl/tl_debounce.sv | 62 ++++++
 rtl/tl_sensor_cond.sv | 84 ++++++++
 3 files changed

// File: rtl/tl_sensor_pkg.sv
// Shared constants for the loop-detector conditioning stage.
// Lane order matches the arr/dep bit order.
package tl_sensor_pkg;

  localparam int NUM_LANES   = 4;
  localparam int LANE_A      = 0;
  localparam int LANE_AL     = 1;
  localparam int LANE_B      = 2;
  localparam int LANE_BL     = 3;

  localparam int DEB_CYC_DEF = 4;
  localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchronizer, debouncer and rising-edge detector
// for one raw detector level.
module tl_debounce
  import tl_sensor_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic ev
);

  localparam int DW = $clog2(DEB_CYC + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          deb_q, deb_d;
  logic          prev_q, prev_d;
  logic [DW-1:0] dc_q, dc_d;
  logic          diff;
  logic          dc_hit;

  assign diff   = s2_q != deb_q;
  assign dc_hit = diff &&
    ((DW+1)'(dc_q) + (DW+1)'(1) == (DW+1)'(DEB_CYC));

  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    prev_d = deb_q;
    deb_d  = deb_q;
    dc_d   = '0;
    unique case (1'b1)
      !diff:  dc_d = '0;
      dc_hit: begin
        deb_d = s2_q;
        dc_d  = '0;
      end
      default: dc_d = dc_q + DW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
      dc_q   <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      deb_q  <= deb_d;
      prev_q <= prev_d;
      dc_q   <= dc_d;
    end
  end

  assign ev = deb_q & ~prev_q;

endmodule

// File: rtl/tl_sensor_cond.sv
// Per-lane saturating occupancy counters fed by debounced
// arrival/departure events; drives the controller T inputs.
module tl_sensor_cond
  import tl_sensor_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             arr,
  input  logic [3:0]             dep,
  output logic                   Ta,
  output logic                   Tal,
  output logic                   Tb,
  output logic                   Tbl,
  output logic [4*CNT_W-1:0]     occ,
  output logic [3:0]             ovf,
  output logic [3:0]             unf
);

  logic [NUM_LANES-1:0] arr_ev;
  logic [NUM_LANES-1:0] dep_ev;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tl_debounce #(.DEB_CYC(DEB_CYC)) u_arr (
      .clk   (clk),
      .reset (reset),
      .raw   (arr[i]),
      .ev    (arr_ev[i])
    );
    tl_debounce #(.DEB_CYC(DEB_CYC)) u_dep (
      .clk   (clk),
      .reset (reset),
      .raw   (dep[i]),
      .ev    (dep_ev[i])
    );
  end

  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_LANES-1:0]            ovf_q, ovf_d;
  logic [NUM_LANES-1:0]            unf_q, unf_d;

  // Simultaneous arrival and departure cancel, flags untouched.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      unique case (1'b1)
        arr_ev[i] && !dep_ev[i]: begin
          if (&cnt_q[i]) ovf_d[i] = 1'b1;
          else cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        dep_ev[i] && !arr_ev[i]: begin
          if (cnt_q[i] == '0) unf_d[i] = 1'b1;
          else cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign occ = cnt_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign Ta  = |cnt_q[LANE_A];
  assign Tal = |cnt_q[LANE_AL];
  assign Tb  = |cnt_q[LANE_B];
  assign Tbl = |cnt_q[LANE_BL];

endmodule
